axi_rdata_router: RTL and testbench
===================================

# axi_rdata_router

Parametrised AXI read-data (R) channel router between NUM_S slave read ports and NUM_M master read ports in the AXI interconnect. Routes each slave's R beats to the master encoded in the upper RID bits, arbitrates round-robin per master among competing slaves, and holds each grant for the whole burst until the RLAST beat is accepted. Each master port has a registered 2-entry skid buffer, so all outputs are flop-driven and throughput is one beat per cycle.

## Interface
- NUM_M, 3, number of master ports (1..8)
- NUM_S, 8, number of slave ports (1..16)
- ID_BITS, 4, master-side RID width
- IDS_BITS, 8, slave-side RID width; RIDS[IDS_BITS-1:ID_BITS] is the master index, RIDS[ID_BITS-1:0] is the master RID
- DATA_BITS, 32, RDATA width
- Reset: one clock; reset is asynchronous and active-high.
- ACLK  in  1  clock
- ARESET  in  1  asynchronous active-high reset
- S_RID  in  NUM_S*IDS_BITS  slave RIDs, slave s at [s*IDS_BITS +: IDS_BITS]
- S_RDATA  in  NUM_S*DATA_BITS  slave read data
- S_RRESP  in  NUM_S*2  slave responses
- S_RLAST  in  NUM_S  slave last-beat flags
- S_RVALID  in  NUM_S  slave valid
- S_RREADY  out  NUM_S  ready to slaves
- M_RID  out  NUM_M*ID_BITS  master RID (low ID_BITS of S_RID)
- M_RDATA  out  NUM_M*DATA_BITS  master read data
- M_RRESP  out  NUM_M*2  master response
- M_RLAST  out  NUM_M  master last flag
- M_RVALID  out  NUM_M  master valid
- M_RREADY  in  NUM_M  ready from masters
- ERR_DROP  out  1  one-cycle pulse: beat with out-of-range master index was sunk

## Operation
- Target decode: tgt(s) = S_RID[s] upper field. Slave s requests master m when S_RVALID[s] and tgt(s)==m.
- Per-master FSM, states IDLE and BURST; grant register g[m] and round-robin pointer rr[m] (last granted slave).
- IDLE: if any slave requests m, register g[m] = first requesting slave searching from rr[m]+1 upward, wrapping modulo NUM_S; go BURST. No beat is accepted in IDLE.
- BURST: S_RREADY[g[m]] = ~full[m] (full[m] registered, count==2). Beat accepted when S_RVALID & S_RREADY; pushed into the skid buffer. On an accepted beat with S_RLAST=1: rr[m] = g[m], go IDLE.
- Non-granted slaves targeting m see S_RREADY=0 and wait; their beats are never dropped or reordered.
- Bad index (tgt(s) >= NUM_M): S_RREADY[s]=1 combinationally, beat discarded, ERR_DROP=1 on the following cycle; repeats per beat.
- Skid buffer: 2 entries, FIFO order. Head drives M_R* outputs; pop on M_RVALID & M_RREADY. Simultaneous push and pop keeps count unchanged. Push never occurs when full.
- Masters are independent: different masters may each run a burst from different slaves in the same cycle.

## Timing
- Reset values: M_RVALID=0, M_RID/M_RDATA/M_RRESP/M_RLAST=0, S_RREADY=0 (except the combinational bad-index sink), ERR_DROP=0, all FSMs IDLE, rr[m]=NUM_S-1 so slave 0 has first priority, buffers empty.
- First-beat latency: request seen in cycle 0 (IDLE), grant in cycle 1 with S_RREADY=1, beat on M_R* in cycle 2.
- Subsequent beats: 1 cycle slave-to-master, one beat per cycle sustained while M_RREADY=1.
- Inter-burst gap: after RLAST is accepted, at least one IDLE cycle occurs before the next grant on that master.
- Backpressure: with M_RREADY=0, two beats are buffered, then S_RREADY drops on the cycle after full is registered. Master outputs stay stable while M_RVALID=1 and M_RREADY=0.
- Output M_R* signals change only on pop or on push into an empty buffer.
- ARESET mid-burst: all state clears immediately. Buffered beats are lost and the in-flight burst is abandoned; recovery is the system's responsibility.
- Single-beat burst (RLAST on first beat): grant is released the same cycle it is accepted.

## Test plan
- Single slave burst: S2 sends 4 beats with RID=8'h15 (master 1, ID 5), M_RREADY=1 -> M_RVALID[1] first high 2 cycles after S_RVALID, 4 consecutive beats, M_RID=4'h5, RLAST on beat 4, other masters idle.
- Contention and round-robin: S0 and S3 both target M0 with 2-beat bursts, repeated 2 times each -> grant order S0, S3, S0, S3; no interleaving within a burst.
- Backpressure: M_RREADY[0]=0 during an 8-beat burst -> exactly 2 beats accepted, then S_RREADY low. Release -> all 8 beats delivered in order, data intact.
- Parallel masters: S1->M0 and S4->M2 concurrently -> both streams at 1 beat/cycle, no cross-talk.
- Bad index: NUM_M=3, S5 sends RID=8'h35 -> S_RREADY[5]=1, no M_RVALID, ERR_DROP pulses 1 cycle later.
- Reset mid-burst: assert ARESET on beat 2 of 4 -> all outputs zero immediately. After release, a new burst from slave 0 routes normally.

Source files
------------

// File: rtl/axi_rdata_router.sv
// rtl/axi_rdata_router.sv - AXI R-channel router from NUM_S slave ports to NUM_M master ports
// Purpose: each slave's read-data beats go to the master named by the upper RID
// field. Each master arbitrates round-robin among requesting slaves and holds the
// grant for a whole burst, until the RLAST beat is accepted. A 2-entry skid buffer
// per master keeps the master-side outputs on flops at one beat per cycle.
// Ports:
//   ACLK, ARESET                          clock, asynchronous active-high reset
//   S_RID/S_RDATA/S_RRESP/S_RLAST/S_RVALID slave R channels, packed per slave
//   S_RREADY                              ready back to each slave
//   M_RID/M_RDATA/M_RRESP/M_RLAST/M_RVALID master R channels, packed per master
//   M_RREADY                              ready from each master
//   ERR_DROP                              pulse the cycle after an out-of-range beat was sunk
module axi_rdata_router #(
  parameter int NUM_M     = 3,
  parameter int NUM_S     = 8,
  parameter int ID_BITS   = 4,
  parameter int IDS_BITS  = 8,
  parameter int DATA_BITS = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [NUM_S*IDS_BITS-1:0]     S_RID,
  input  logic [NUM_S*DATA_BITS-1:0]    S_RDATA,
  input  logic [NUM_S*2-1:0]            S_RRESP,
  input  logic [NUM_S-1:0]              S_RLAST,
  input  logic [NUM_S-1:0]              S_RVALID,
  output logic [NUM_S-1:0]              S_RREADY,
  output logic [NUM_M*ID_BITS-1:0]      M_RID,
  output logic [NUM_M*DATA_BITS-1:0]    M_RDATA,
  output logic [NUM_M*2-1:0]            M_RRESP,
  output logic [NUM_M-1:0]              M_RLAST,
  output logic [NUM_M-1:0]              M_RVALID,
  input  logic [NUM_M-1:0]              M_RREADY,
  output logic                          ERR_DROP
);
  localparam int SW = (NUM_S > 1) ? $clog2(NUM_S) : 1;
  localparam int MW = IDS_BITS - ID_BITS;
  localparam int PW = ID_BITS + DATA_BITS + 3;

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q [NUM_M];
  state_t          state_d [NUM_M];
  logic [SW-1:0]   g_q     [NUM_M];
  logic [SW-1:0]   g_d     [NUM_M];
  logic [SW-1:0]   rr_q    [NUM_M];
  logic [SW-1:0]   rr_d    [NUM_M];
  logic [1:0]      count_q [NUM_M];
  logic [PW-1:0]   head_q  [NUM_M];
  logic [PW-1:0]   tail_q  [NUM_M];
  logic            err_q;

  logic [MW-1:0]   tgt     [NUM_S];
  logic [NUM_S-1:0] bad;
  logic [NUM_S-1:0] rready;
  logic [NUM_M-1:0] push;
  logic [NUM_M-1:0] pop;
  logic [NUM_M-1:0] last_acc;
  logic [PW-1:0]   push_data [NUM_M];

  // First requester strictly after ptr, wrapping, so the last winner goes to the back.
  function automatic logic [SW-1:0] rr_pick(input logic [NUM_S-1:0] r, input logic [SW-1:0] ptr);
    logic [SW-1:0] sel;
    logic          found;
    int            idx;
    sel   = ptr;
    found = 1'b0;
    for (int i = 1; i <= NUM_S; i++) begin
      idx = (int'(ptr) + i) % NUM_S;
      if (!found && r[idx]) begin
        found = 1'b1;
        sel   = SW'(idx);
      end
    end
    return sel;
  endfunction

  always_comb begin
    for (int s = 0; s < NUM_S; s++) begin
      tgt[s] = S_RID[s*IDS_BITS + ID_BITS +: MW];
      bad[s] = int'(tgt[s]) >= NUM_M;
    end
  end

  // State register and skid buffers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int m = 0; m < NUM_M; m++) begin
        state_q[m] <= IDLE;
        g_q[m]     <= '0;
        rr_q[m]    <= SW'(NUM_S - 1);
        count_q[m] <= 2'd0;
        head_q[m]  <= '0;
        tail_q[m]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int m = 0; m < NUM_M; m++) begin
        state_q[m] <= state_d[m];
        g_q[m]     <= g_d[m];
        rr_q[m]    <= rr_d[m];
        case ({push[m], pop[m]})
          2'b10: begin
            if (count_q[m] == 2'd0) head_q[m] <= push_data[m];
            else                    tail_q[m] <= push_data[m];
            count_q[m] <= count_q[m] + 2'd1;
          end
          2'b01: begin
            // Head is left untouched when draining the last entry so outputs
            // only move on a real pop-with-data or a push into an empty buffer.
            if (count_q[m] == 2'd2) head_q[m] <= tail_q[m];
            count_q[m] <= count_q[m] - 2'd1;
          end
          2'b11: begin
            if (count_q[m] == 2'd1) head_q[m] <= push_data[m];
            else begin
              head_q[m] <= tail_q[m];
              tail_q[m] <= push_data[m];
            end
          end
          default: ;
        endcase
      end
      // Bad-index slaves are always ready, so a valid beat is a sunk beat.
      err_q <= |(bad & S_RVALID);
    end
  end

  // Next-state: grant in IDLE, release on the accepted RLAST beat.
  always_comb begin
    for (int m = 0; m < NUM_M; m++) begin
      logic [NUM_S-1:0] req;
      for (int s = 0; s < NUM_S; s++)
        req[s] = S_RVALID[s] && !bad[s] && (int'(tgt[s]) == m);
      state_d[m] = state_q[m];
      g_d[m]     = g_q[m];
      rr_d[m]    = rr_q[m];
      case (state_q[m])
        IDLE: begin
          if (|req) begin
            state_d[m] = BURST;
            g_d[m]     = rr_pick(req, rr_q[m]);
          end
        end
        BURST: begin
          if (last_acc[m]) begin
            state_d[m] = IDLE;
            rr_d[m]    = g_q[m];
          end
        end
        default: state_d[m] = IDLE;
      endcase
    end
  end

  // Outputs: slave readies, buffer push/pop and the granted slave's payload.
  always_comb begin : out_comb
    int sel;
    sel      = 0;
    rready   = bad;
    push     = '0;
    pop      = '0;
    last_acc = '0;
    for (int m = 0; m < NUM_M; m++) begin
      sel          = int'(g_q[m]);
      push_data[m] = {S_RID[sel*IDS_BITS +: ID_BITS], S_RDATA[sel*DATA_BITS +: DATA_BITS],
                      S_RRESP[sel*2 +: 2], S_RLAST[sel]};
      if (state_q[m] == BURST && count_q[m] != 2'd2) begin
        rready[sel] = 1'b1;
        push[m]     = S_RVALID[sel];
        last_acc[m] = S_RVALID[sel] && S_RLAST[sel];
      end
      pop[m] = (count_q[m] != 2'd0) && M_RREADY[m];
    end
  end

  always_comb begin
    for (int m = 0; m < NUM_M; m++) begin
      {M_RID[m*ID_BITS +: ID_BITS], M_RDATA[m*DATA_BITS +: DATA_BITS],
       M_RRESP[m*2 +: 2], M_RLAST[m]} = head_q[m];
      M_RVALID[m] = (count_q[m] != 2'd0);
    end
  end

  assign S_RREADY = rready;
  assign ERR_DROP = err_q;

endmodule

// File: tb/tb_axi_rdata_router.sv
// tb/tb_axi_rdata_router.sv - randomized self-checking bench for axi_rdata_router
module tb_axi_rdata_router;
  localparam int NUM_M = 3, NUM_S = 8, ID_BITS = 4, IDS_BITS = 8, DATA_BITS = 32;
  localparam int OW = ID_BITS + DATA_BITS + 3;

  logic                       ACLK = 1'b0;
  logic                       ARESET;
  logic [NUM_S*IDS_BITS-1:0]  S_RID;
  logic [NUM_S*DATA_BITS-1:0] S_RDATA;
  logic [NUM_S*2-1:0]         S_RRESP;
  logic [NUM_S-1:0]           S_RLAST, S_RVALID, S_RREADY;
  logic [NUM_M*ID_BITS-1:0]   M_RID;
  logic [NUM_M*DATA_BITS-1:0] M_RDATA;
  logic [NUM_M*2-1:0]         M_RRESP;
  logic [NUM_M-1:0]           M_RLAST, M_RVALID, M_RREADY;
  logic                       ERR_DROP;

  always #5 ACLK = ~ACLK;

  axi_rdata_router #(.NUM_M(NUM_M), .NUM_S(NUM_S), .ID_BITS(ID_BITS),
                     .IDS_BITS(IDS_BITS), .DATA_BITS(DATA_BITS)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
    .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .ERR_DROP(ERR_DROP)
  );

  typedef struct packed {
    logic [IDS_BITS-1:0]  rid;
    logic [DATA_BITS-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } beat_t;

  // Slave-side beats still to send, and per (slave, master) the beats each master must see.
  beat_t sq [NUM_S][$];
  beat_t eq [NUM_S*NUM_M][$];
  int    mtimes [NUM_M][$];
  int    order  [NUM_M][$];
  int    cur_src [NUM_M];
  int    acc_cnt [NUM_S];
  logic [NUM_S-1:0] hold;
  logic [NUM_M-1:0] prev_stall;
  logic [OW-1:0]    prev_out [NUM_M];
  logic             err_exp;
  int  cyc, n_checks, n_errors, burst_seq;
  bit  gaps, mrdy_rand;
  logic [NUM_M-1:0] mrdy_fixed;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add_burst(input int s, input logic [7:0] rid, input int len);
    beat_t b;
    int t;
    t = int'(rid[7:4]);
    for (int i = 0; i < len; i++) begin
      b.rid  = rid;
      b.data = {4'(s), 4'(burst_seq), 8'(i), 16'($urandom)};
      b.resp = 2'($urandom);
      b.last = (i == len - 1);
      sq[s].push_back(b);
      if (t < NUM_M) eq[s*NUM_M + t].push_back(b);
    end
    burst_seq++;
  endtask

  task automatic drive();
    beat_t b;
    for (int s = 0; s < NUM_S; s++) begin
      if (sq[s].size() > 0 && (hold[s] || !gaps || $urandom_range(3) != 0)) begin
        b = sq[s][0];
        S_RVALID[s] = 1'b1;
        S_RID[s*IDS_BITS +: IDS_BITS]     = b.rid;
        S_RDATA[s*DATA_BITS +: DATA_BITS] = b.data;
        S_RRESP[s*2 +: 2]                 = b.resp;
        S_RLAST[s]                        = b.last;
      end else begin
        S_RVALID[s] = 1'b0;
        S_RID[s*IDS_BITS +: IDS_BITS]     = gaps ? IDS_BITS'($urandom) : '0;
        S_RDATA[s*DATA_BITS +: DATA_BITS] = gaps ? DATA_BITS'($urandom) : '0;
        S_RRESP[s*2 +: 2]                 = '0;
        S_RLAST[s]                        = gaps ? 1'($urandom) : 1'b0;
      end
    end
    M_RREADY = mrdy_rand ? NUM_M'($urandom) : mrdy_fixed;
  endtask

  // One clock: sample at the falling edge, update the model, drive after the rising edge.
  task automatic cycle();
    logic [NUM_S-1:0] sacc;
    logic [NUM_M-1:0] macc;
    logic [OW-1:0]    cur;
    beat_t b;
    int s;
    bit avail;
    @(negedge ACLK);
    check("err_drop", 64'(ERR_DROP), 64'(err_exp));
    sacc    = S_RVALID & S_RREADY;
    macc    = M_RVALID & M_RREADY;
    err_exp = 1'b0;
    for (int i = 0; i < NUM_S; i++) begin
      hold[i] = S_RVALID[i] & ~S_RREADY[i];
      if (sacc[i] && sq[i].size() > 0) begin
        b = sq[i].pop_front();
        acc_cnt[i]++;
        if (int'(b.rid[7:4]) >= NUM_M) err_exp = 1'b1;
      end
    end
    for (int m = 0; m < NUM_M; m++) begin
      cur = {M_RID[m*ID_BITS +: ID_BITS], M_RDATA[m*DATA_BITS +: DATA_BITS],
             M_RRESP[m*2 +: 2], M_RLAST[m]};
      if (prev_stall[m]) check("stall_hold", 64'({M_RVALID[m], cur}), 64'({1'b1, prev_out[m]}));
      prev_stall[m] = M_RVALID[m] & ~M_RREADY[m];
      prev_out[m]   = cur;
      if (macc[m]) begin
        s = int'(M_RDATA[m*DATA_BITS + 28 +: 4]);
        if (cur_src[m] < 0) begin
          cur_src[m] = s;
          order[m].push_back(s);
        end
        check("burst_src", 64'(s), 64'(cur_src[m]));
        avail = (s < NUM_S) && (eq[s*NUM_M + m].size() > 0);
        check("m_exp_avail", 64'(avail), 64'(1));
        if (avail) begin
          b = eq[s*NUM_M + m].pop_front();
          check("m_beat", 64'(cur), 64'({b.rid[ID_BITS-1:0], b.data, b.resp, b.last}));
        end
        mtimes[m].push_back(cyc);
        if (M_RLAST[m]) cur_src[m] = -1;
      end
    end
    @(posedge ACLK);
    #1;
    cyc++;
    drive();
  endtask

  function automatic bit all_done();
    bit d = (M_RVALID == '0);
    for (int s = 0; s < NUM_S; s++) if (sq[s].size() != 0) d = 1'b0;
    for (int i = 0; i < NUM_S*NUM_M; i++) if (eq[i].size() != 0) d = 1'b0;
    return d;
  endfunction

  task automatic run_idle(input int budget);
    int n = 0;
    while (!all_done() && n < budget) begin
      cycle();
      n++;
    end
    check("drain_timeout", 64'(all_done()), 64'(1));
  endtask

  task automatic reset_dut();
    ARESET = 1'b1;
    for (int s = 0; s < NUM_S; s++) begin sq[s].delete(); acc_cnt[s] = 0; end
    for (int i = 0; i < NUM_S*NUM_M; i++) eq[i].delete();
    for (int m = 0; m < NUM_M; m++) begin
      mtimes[m].delete(); order[m].delete(); cur_src[m] = -1;
    end
    hold = '0; prev_stall = '0; err_exp = 1'b0;
    gaps = 1'b0; mrdy_rand = 1'b0; mrdy_fixed = '1;
    drive();
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
  endtask

  int t0, n, s, t;

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; burst_seq = 0;
    ARESET = 1'b1; S_RID = '0; S_RDATA = '0; S_RRESP = '0; S_RLAST = '0; S_RVALID = '0;
    M_RREADY = '0;
    reset_dut();
    #1;
    check("rst_mvalid", 64'(M_RVALID), 64'(0));
    check("rst_mdata", 64'(|{M_RDATA, M_RID, M_RRESP, M_RLAST}), 64'(0));
    check("rst_srready", 64'(S_RREADY), 64'(0));
    check("rst_err", 64'(ERR_DROP), 64'(0));

    // Single slave burst: S2 -> M1, ID 5.
    add_burst(2, 8'h15, 4); drive(); t0 = cyc;
    #1 check("single_wait", 64'(S_RREADY[2]), 64'(0));
    cycle();
    #1 check("single_grant", 64'(S_RREADY[2]), 64'(1));
    run_idle(50);
    check("single_cnt", 64'(mtimes[1].size()), 64'(4));
    for (int i = 0; i < 4; i++)
      if (i < mtimes[1].size()) check("single_time", 64'(mtimes[1][i]), 64'(t0 + 2 + i));
    check("single_other", 64'(mtimes[0].size() + mtimes[2].size()), 64'(0));

    // Contention on M0 between S0 and S3.
    reset_dut();
    add_burst(0, 8'h01, 2); add_burst(0, 8'h02, 2);
    add_burst(3, 8'h03, 2); add_burst(3, 8'h04, 2);
    drive(); run_idle(100);
    check("rr_count", 64'(order[0].size()), 64'(4));
    if (order[0].size() == 4)
      check("rr_order", 64'({4'(order[0][0]), 4'(order[0][1]), 4'(order[0][2]), 4'(order[0][3])}),
            64'(16'h0303));

    // Backpressure on M0.
    reset_dut();
    mrdy_fixed = 3'b110;
    add_burst(0, 8'h07, 8); drive();
    repeat (8) cycle();
    check("bp_accepted", 64'(acc_cnt[0]), 64'(2));
    #1 check("bp_rready", 64'(S_RREADY[0]), 64'(0));
    mrdy_fixed = '1; drive();
    run_idle(100);
    check("bp_delivered", 64'(mtimes[0].size()), 64'(8));

    // Parallel masters.
    reset_dut();
    add_burst(1, 8'h0A, 4); add_burst(4, 8'h2B, 4); drive(); t0 = cyc;
    run_idle(50);
    for (int k = 0; k < 2; k++) begin
      int m;
      m = k * 2;
      check("par_cnt", 64'(mtimes[m].size()), 64'(4));
      for (int i = 0; i < 4; i++)
        if (i < mtimes[m].size()) check("par_time", 64'(mtimes[m][i]), 64'(t0 + 2 + i));
    end

    // Bad master index.
    reset_dut();
    add_burst(5, 8'h35, 1); drive();
    #1 check("bad_rready", 64'(S_RREADY[5]), 64'(1));
    cycle();
    check("bad_err_pulse", 64'(ERR_DROP), 64'(1));
    check("bad_mvalid", 64'(M_RVALID), 64'(0));
    cycle();
    check("bad_err_clear", 64'(ERR_DROP), 64'(0));
    check("bad_mvalid2", 64'(M_RVALID), 64'(0));

    // Reset mid-burst, then recovery.
    reset_dut();
    add_burst(0, 8'h00, 4); drive();
    n = 0;
    while (acc_cnt[0] < 2 && n < 20) begin cycle(); n++; end
    check("mid_acc", 64'(acc_cnt[0]), 64'(2));
    check("mid_busy", 64'(M_RVALID[0]), 64'(1));
    ARESET = 1'b1;
    #1;
    check("mid_rst_mvalid", 64'(M_RVALID), 64'(0));
    check("mid_rst_mout", 64'(|{M_RDATA, M_RID, M_RRESP, M_RLAST}), 64'(0));
    check("mid_rst_rready", 64'(S_RREADY), 64'(0));
    reset_dut();
    add_burst(0, 8'h02, 3); drive();
    run_idle(50);
    check("post_rst_cnt", 64'(mtimes[0].size()), 64'(3));

    // Randomized traffic with gaps, random backpressure and some bad indices.
    reset_dut();
    gaps = 1'b1; mrdy_rand = 1'b1;
    repeat (80) begin
      s = $urandom_range(NUM_S - 1);
      t = $urandom_range(NUM_M);
      add_burst(s, {4'(t), 4'($urandom_range(15))}, $urandom_range(6, 1));
    end
    drive();
    run_idle(6000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
